// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU; one partial product per falling edge.
// Magnitudes are multiplied unsigned and the sign is applied once, in the FIX step.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fixed;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    a_mag      = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag      = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    addend     = mplier_q[0] ? mcand_q : '0;
    sum        = {1'b0, acc_q} + {1'b0, addend};
    prod       = {acc_q, mplier_q};
    prod_fixed = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // The multiplier register doubles as the low half of the product.
        {acc_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
        count_d           = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        {hi_d, lo_d} = prod_fixed;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomized checks of mult_seq against a 64-bit arithmetic product.
module tb_mult_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] prev_p = '0;

  mult_seq #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .a(a),
    .b(b),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  // The DUT updates on falling edges; sample and drive just after rising edges.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (sg) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic sg, input logic [31:0] x, input logic [31:0] y);
    start     = 1'b1;
    is_signed = sg;
    a         = x;
    b         = y;
  endtask

  // Counts busy samples; drops start (and scrambles operands) after `hold` of them.
  task automatic wait_done(input int hold, input int exp_busy, input logic [63:0] exp, input string tag);
    int n = 0;
    logic fin = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (busy !== 1'b1) begin
        fin = 1'b1;
        break;
      end
      n++;
      check({tag, ".hold_hilo"}, {hi, lo}, prev_p);
      check({tag, ".done_low_busy"}, {63'd0, done}, 64'd0);
      if (n == hold) begin
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
      end
    end
    check({tag, ".finished"}, {63'd0, fin}, 64'd1);
    check({tag, ".busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, ".done_pulse"}, {63'd0, done}, 64'd1);
    check({tag, ".product"}, {hi, lo}, exp);
    prev_p = exp;
  endtask

  task automatic do_op(input logic sg, input logic [31:0] x, input logic [31:0] y,
                       input int hold, input string tag);
    logic [63:0] exp;
    exp = ref_prod(sg, x, y);
    start_op(sg, x, y);
    wait_done(hold, W + 1, exp, tag);
    tick();
    check({tag, ".done_width"}, {63'd0, done}, 64'd0);
    check({tag, ".idle_hilo"}, {hi, lo}, prev_p);
    check({tag, ".idle_busy"}, {63'd0, busy}, 64'd0);
    $display("%s: signed=%0d a=0x%h b=0x%h -> hi=0x%h lo=0x%h", tag, sg, x, y, hi, lo);
  endtask

  initial begin
    logic [63:0] exp;

    #1;
    check("reset.hi_lo", {hi, lo}, 64'd0);
    check("reset.busy", {63'd0, busy}, 64'd0);
    check("reset.done", {63'd0, done}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("idle.busy", {63'd0, busy}, 64'd0);
    check("idle.hi_lo", {hi, lo}, 64'd0);

    do_op(1'b0, 32'd3, 32'd5, 1, "multu_3x5");
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max");
    do_op(1'b1, 32'hFFFF_FFFE, 32'd3, 1, "mult_m2x3");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1, "mult_min");
    do_op(1'b0, 32'd7, 32'd6, 1, "multu_7x6");
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5, "multu_hold5");

    // start held through completion: ignored on the FIX edge, accepted on the next one
    exp = ref_prod(1'b1, 32'hFFFF_FFF9, 32'd9);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd9);
    wait_done(1000, W + 1, exp, "b2b_first");
    tick();
    check("b2b.accept_busy", {63'd0, busy}, 64'd1);
    check("b2b.accept_done", {63'd0, done}, 64'd0);
    wait_done(1, W, exp, "b2b_second");
    tick();
    check("b2b.done_width", {63'd0, done}, 64'd0);
    $display("b2b: signed=1 a=0xfffffff9 b=0x00000009 -> hi=0x%h lo=0x%h", hi, lo);

    // reset mid-operation discards everything immediately
    start_op(1'b0, 32'd9, 32'd9);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("midreset.busy", {63'd0, busy}, 64'd0);
    check("midreset.done", {63'd0, done}, 64'd0);
    check("midreset.hi_lo", {hi, lo}, 64'd0);
    prev_p = '0;
    tick();
    reset = 1'b1;
    tick();
    check("postreset.busy", {63'd0, busy}, 64'd0);
    do_op(1'b0, 32'd9, 32'd9, 1, "multu_9x9");

    for (int i = 0; i < 1000; i++) begin
      logic        sg;
      logic [31:0] x;
      logic [31:0] y;
      sg = 1'($urandom);
      x  = pick();
      y  = pick();
      do_op(sg, x, y, int'($urandom_range(1, 6)), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
